// File: rtl/video_pkg.sv
// Shared video definitions: renderer FSM state encoding and helpers that size
// pixel coordinates and linear frame-buffer addresses from the frame geometry.
package video_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    FILL  = 2'd2,
    DONE  = 2'd3
  } fill_state_t;

  function automatic int x_width(input int hor_active_pixels);
    return $clog2(hor_active_pixels);
  endfunction

  function automatic int y_width(input int ver_active_pixels);
    return $clog2(ver_active_pixels);
  endfunction

  function automatic int pixel_addr_width(input int hor_active_pixels,
                                          input int ver_active_pixels);
    return $clog2(hor_active_pixels * ver_active_pixels);
  endfunction

endpackage

// File: rtl/rect_filler.sv
// Fills a clipped axis-aligned rectangle into the frame buffer write port,
// one pixel per enabled cycle in raster order, using incremental addressing.
module rect_filler
  import video_pkg::*;
#(
  parameter int HOR_ACTIVE_PIXELS = 640,
  parameter int VER_ACTIVE_PIXELS = 480,
  localparam int X_WIDTH = x_width(HOR_ACTIVE_PIXELS),
  localparam int Y_WIDTH = y_width(VER_ACTIVE_PIXELS),
  localparam int PIXEL_ADDR_WIDTH = pixel_addr_width(HOR_ACTIVE_PIXELS, VER_ACTIVE_PIXELS)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        ce,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [X_WIDTH-1:0]          cmd_x,
  input  logic [Y_WIDTH-1:0]          cmd_y,
  input  logic [X_WIDTH:0]            cmd_w,
  input  logic [Y_WIDTH:0]            cmd_h,
  input  logic                        cmd_color,
  output logic                        wr_en,
  output logic [PIXEL_ADDR_WIDTH-1:0] wr_addr,
  output logic                        wr_data,
  output logic                        busy,
  output logic                        done
);

  fill_state_t                 state;
  logic [X_WIDTH-1:0]          x_start;
  logic [Y_WIDTH-1:0]          y_start;
  logic [X_WIDTH:0]            w_r;
  logic [Y_WIDTH:0]            h_r;
  logic                        color_r;
  logic [X_WIDTH:0]            x_end;
  logic [Y_WIDTH:0]            y_end;
  logic [X_WIDTH-1:0]          col;
  logic [Y_WIDTH-1:0]          row;
  logic [PIXEL_ADDR_WIDTH-1:0] addr;
  logic [PIXEL_ADDR_WIDTH-1:0] row_addr;

  logic [X_WIDTH+1:0]          x_sum;
  logic [Y_WIDTH+1:0]          y_sum;
  logic [X_WIDTH:0]            x_clip;
  logic [Y_WIDTH:0]            y_clip;
  logic                        is_empty;
  logic                        last_col;
  logic                        last_row;
  logic [PIXEL_ADDR_WIDTH-1:0] start_addr;

  // Sums are one bit wider than their operands so a large width never wraps
  // back inside the frame before clipping.
  always_comb begin
    x_sum = (X_WIDTH+2)'(x_start) + (X_WIDTH+2)'(w_r);
    y_sum = (Y_WIDTH+2)'(y_start) + (Y_WIDTH+2)'(h_r);
    x_clip = (x_sum > (X_WIDTH+2)'(HOR_ACTIVE_PIXELS)) ?
             (X_WIDTH+1)'(HOR_ACTIVE_PIXELS) : x_sum[X_WIDTH:0];
    y_clip = (y_sum > (Y_WIDTH+2)'(VER_ACTIVE_PIXELS)) ?
             (Y_WIDTH+1)'(VER_ACTIVE_PIXELS) : y_sum[Y_WIDTH:0];
    is_empty = (w_r == '0) || (h_r == '0) ||
               ((X_WIDTH+1)'(x_start) >= (X_WIDTH+1)'(HOR_ACTIVE_PIXELS)) ||
               ((Y_WIDTH+1)'(y_start) >= (Y_WIDTH+1)'(VER_ACTIVE_PIXELS));
    start_addr = PIXEL_ADDR_WIDTH'(y_start) * PIXEL_ADDR_WIDTH'(HOR_ACTIVE_PIXELS) +
                 PIXEL_ADDR_WIDTH'(x_start);
    last_col = ((X_WIDTH+1)'(col) + (X_WIDTH+1)'(1)) == x_end;
    last_row = ((Y_WIDTH+1)'(row) + (Y_WIDTH+1)'(1)) == y_end;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      x_start  <= '0;
      y_start  <= '0;
      w_r      <= '0;
      h_r      <= '0;
      color_r  <= 1'b0;
      x_end    <= '0;
      y_end    <= '0;
      col      <= '0;
      row      <= '0;
      addr     <= '0;
      row_addr <= '0;
    end else if (ce) begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            x_start <= cmd_x;
            y_start <= cmd_y;
            w_r     <= cmd_w;
            h_r     <= cmd_h;
            color_r <= cmd_color;
            state   <= SETUP;
          end
        end
        // The only multiply: the first pixel's address; FILL steps from here.
        SETUP: begin
          x_end    <= x_clip;
          y_end    <= y_clip;
          col      <= x_start;
          row      <= y_start;
          addr     <= start_addr;
          row_addr <= start_addr;
          state    <= is_empty ? DONE : FILL;
        end
        FILL: begin
          if (last_col) begin
            if (last_row) begin
              state <= DONE;
            end else begin
              row      <= row + Y_WIDTH'(1);
              col      <= x_start;
              row_addr <= row_addr + PIXEL_ADDR_WIDTH'(HOR_ACTIVE_PIXELS);
              addr     <= row_addr + PIXEL_ADDR_WIDTH'(HOR_ACTIVE_PIXELS);
            end
          end else begin
            col  <= col + X_WIDTH'(1);
            addr <= addr + PIXEL_ADDR_WIDTH'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign wr_en     = ce && (state == FILL);
  assign wr_data   = (state == FILL) && color_r;
  assign wr_addr   = addr;
  assign done      = ce && (state == DONE);

endmodule

// File: tb/tb_rect_filler.sv
// Scoreboard bench for rect_filler: stimulus pushes hand-computed writes and
// done pulses into a queue that a negedge monitor pops as the DUT produces them.
module tb_rect_filler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ce;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [9:0]  cmd_x;
  logic [8:0]  cmd_y;
  logic [10:0] cmd_w;
  logic [9:0]  cmd_h;
  logic        cmd_color;
  logic        wr_en;
  logic [18:0] wr_addr;
  logic        wr_data;
  logic        busy;
  logic        done;

  typedef struct {
    bit is_done;
    int addr;
    bit data;
    int cyc;
  } ev_t;

  ev_t exp_q[$];
  int  plan[$];
  int  cyc        = 0;
  int  checks     = 0;
  int  passed     = 0;
  int  done_count = 0;
  bit  ce_toggle  = 1'b0;

  rect_filler #(
    .HOR_ACTIVE_PIXELS(640),
    .VER_ACTIVE_PIXELS(480)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ce(ce),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_x(cmd_x),
    .cmd_y(cmd_y),
    .cmd_w(cmd_w),
    .cmd_h(cmd_h),
    .cmd_color(cmd_color),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (ce_toggle) ce = ~ce;
    else ce = 1'b1;
  end

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual == expected) passed++;
    else $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
  endtask

  // Monitor: every write or done pulse must match the head of the queue.
  always @(negedge clk) begin
    ev_t e;
    cyc++;
    if (rst_n) begin
      if (!ce) checkOutput("wr_en_while_ce_low", wr_en, 0);
      if (done) done_count++;
      if (wr_en || done) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_event", {wr_en, done}, 0);
        end else begin
          e = exp_q.pop_front();
          checkOutput(e.is_done ? "event_kind_done" : "event_kind_write", done, e.is_done);
          if (!e.is_done && wr_en) begin
            checkOutput("wr_addr", wr_addr, e.addr);
            checkOutput("wr_data", wr_data, e.data);
          end
          if (e.is_done && done) checkOutput("busy_with_done", busy, 1);
          if (e.cyc >= 0) checkOutput("event_cycle", cyc, e.cyc);
        end
      end
    end
  end

  task automatic applyStimulus(input int x, input int y, input int w, input int h,
                               input bit color, output int acc);
    cmd_x     = 10'(x);
    cmd_y     = 9'(y);
    cmd_w     = 11'(w);
    cmd_h     = 10'(h);
    cmd_color = color;
    cmd_valid = 1'b1;
    acc       = -1;
    for (int i = 0; i < 50; i++) begin
      bit ok;
      @(negedge clk);
      ok = cmd_ready && ce;
      @(posedge clk);
      #1;
      if (ok) begin
        acc = cyc;
        break;
      end
    end
    cmd_valid = 1'b0;
    if (acc < 0) checkOutput("accept_timeout", 0, 1);
  endtask

  task automatic pushPlan(input int acc, input bit color, input bit timed);
    if (acc < 0) return;
    foreach (plan[i]) exp_q.push_back('{1'b0, plan[i], color, timed ? acc + 2 + i : -1});
    exp_q.push_back('{1'b1, 0, 1'b0, timed ? acc + 2 + plan.size() : -1});
  endtask

  task automatic waitDone();
    int start;
    bit seen;
    start = done_count;
    seen  = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk);
      if (done_count > start) begin
        seen = 1'b1;
        break;
      end
    end
    #1;
    if (!seen) checkOutput("done_timeout", 0, 1);
    else checkOutput("busy_after_done", busy, 0);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int acc;
    rst_n     = 1'b0;
    ce        = 1'b1;
    cmd_valid = 1'b0;
    cmd_x     = '0;
    cmd_y     = '0;
    cmd_w     = '0;
    cmd_h     = '0;
    cmd_color = 1'b0;
    #12;
    checkOutput("reset_cmd_ready", cmd_ready, 1);
    checkOutput("reset_wr_en", wr_en, 0);
    checkOutput("reset_wr_addr", wr_addr, 0);
    checkOutput("reset_wr_data", wr_data, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] basic 3x2 fill");
    plan = '{642, 643, 644, 1282, 1283, 1284};
    applyStimulus(2, 1, 3, 2, 1'b1, acc);
    pushPlan(acc, 1'b1, 1'b1);
    waitDone();

    $display("[TB] bottom-right corner clip");
    plan = '{307198, 307199};
    applyStimulus(638, 479, 10, 10, 1'b1, acc);
    pushPlan(acc, 1'b1, 1'b1);
    waitDone();

    $display("[TB] empty rectangles");
    plan = '{};
    applyStimulus(5, 5, 0, 4, 1'b1, acc);
    pushPlan(acc, 1'b1, 1'b1);
    waitDone();
    applyStimulus(700, 0, 5, 5, 1'b1, acc);
    pushPlan(acc, 1'b1, 1'b1);
    waitDone();

    $display("[TB] clock enable toggling");
    ce_toggle = 1'b1;
    plan = '{642, 643, 644, 1282, 1283, 1284};
    applyStimulus(2, 1, 3, 2, 1'b1, acc);
    pushPlan(acc, 1'b1, 1'b0);
    waitDone();
    ce_toggle = 1'b0;
    @(posedge clk);
    #2;

    $display("[TB] reset during full-frame fill");
    applyStimulus(0, 0, 640, 480, 1'b1, acc);
    if (acc >= 0)
      for (int i = 0; i < 3; i++) exp_q.push_back('{1'b0, i, 1'b1, acc + 2 + i});
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("abort_wr_en", wr_en, 0);
    checkOutput("abort_wr_addr", wr_addr, 0);
    checkOutput("abort_wr_data", wr_data, 0);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_done", done, 0);
    checkOutput("abort_cmd_ready", cmd_ready, 1);
    #20;
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("after_abort_cmd_ready", cmd_ready, 1);
    checkOutput("after_abort_pending", exp_q.size(), 0);
    repeat (5) @(posedge clk);
    #1;
    plan = '{1925};
    applyStimulus(5, 3, 1, 1, 1'b0, acc);
    pushPlan(acc, 1'b0, 1'b1);
    waitDone();

    $display("[TB] commands offered while busy");
    plan = '{10, 11};
    applyStimulus(10, 0, 2, 1, 1'b1, acc);
    pushPlan(acc, 1'b1, 1'b1);
    cmd_valid = 1'b1;
    for (int k = 0; k <= 4; k++) begin
      if (k < 4) begin
        checkOutput("ready_while_busy", cmd_ready, 0);
        cmd_x     = 10'(k * 7);
        cmd_y     = 9'(k);
        cmd_w     = 11'd5;
        cmd_h     = 10'd5;
        cmd_color = 1'b1;
      end else begin
        checkOutput("ready_after_done", cmd_ready, 1);
        cmd_x     = 10'd1;
        cmd_y     = 9'd2;
        cmd_w     = 11'd1;
        cmd_h     = 10'd1;
        cmd_color = 1'b0;
        plan = '{1281};
        if (acc >= 0) pushPlan(acc + 5, 1'b0, 1'b1);
      end
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
    waitDone();

    repeat (5) @(posedge clk);
    #1;
    checkOutput("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
